// File: rtl/quad_counter_bank_if.sv
// rtl/quad_counter_bank_if.sv - host-side snapshot/read/error bus of quad_counter_bank
interface quad_counter_bank_if #(
    parameter int CHANNELS = 4
);
    logic                snap;
    logic [2:0]          sel;
    logic [1:0]          byte_sel;
    logic                oe;
    logic                clr_err;
    logic [CHANNELS-1:0] err;

    modport master (output snap, sel, byte_sel, oe, clr_err, input err);
    modport slave  (input snap, sel, byte_sel, oe, clr_err, output err);
endinterface

// File: rtl/quad_counter_bank.sv
// rtl/quad_counter_bank.sv - multi-channel quadrature counter bank with snapshot byte read
// Optional illegal-transition flags are built when COUNTER_BANK_ERR_EN is defined.
module quad_counter_bank #(
    parameter int CHANNELS   = 4,
    parameter int SIZE       = 16,
    parameter int FILTER_LEN = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*CHANNELS-1:0] q,
    input  logic [CHANNELS-1:0]   mode,
    output logic [7:0]            dout,
    quad_counter_bank_if.slave    bus
);
    localparam int NBITS  = 2 * CHANNELS;
    localparam int NBYTES = SIZE / 8;
    localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN - 1);
    localparam logic [SIZE-1:0] ONE = {{(SIZE-1){1'b0}}, 1'b1};

    logic [NBITS-1:0]    sync1, sync2, filt, prev;
    logic [3:0]          fcnt [NBITS];
    logic [SIZE-1:0]     cnt [CHANNELS];
    logic [SIZE-1:0]     shadow [CHANNELS];
    logic [CHANNELS-1:0] inc, dec, illegal;
    logic [7:0]          dout_r, rd_byte;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= q;
            sync2 <= sync1;
        end
    end

    // Filter follows sync2 only after FILTER_LEN consecutive disagreeing cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt <= '0;
            for (int i = 0; i < NBITS; i++) fcnt[i] <= 4'd0;
        end else begin
            for (int i = 0; i < NBITS; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= 4'd0;
                end else if (fcnt[i] == FILT_LAST) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= 4'd0;
                end else begin
                    fcnt[i] <= fcnt[i] + 4'd1;
                end
            end
        end
    end

    // Table keyed on {prev, current}; div4 counts only across the 10/00 boundary.
    always_comb begin
        inc     = '0;
        dec     = '0;
        illegal = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            case ({prev[2*n +: 2], filt[2*n +: 2]})
                4'b0001, 4'b0111, 4'b1110:          inc[n] = mode[n];
                4'b1000:                            inc[n] = 1'b1;
                4'b0100, 4'b1101, 4'b1011:          dec[n] = mode[n];
                4'b0010:                            dec[n] = 1'b1;
                4'b0011, 4'b1100, 4'b0110, 4'b1001: illegal[n] = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev <= '0;
            for (int n = 0; n < CHANNELS; n++) begin
                cnt[n]    <= '0;
                shadow[n] <= '0;
            end
        end else begin
            prev <= filt;
            for (int n = 0; n < CHANNELS; n++) begin
                if (inc[n])
                    cnt[n] <= cnt[n] + ONE;
                else if (dec[n])
                    cnt[n] <= cnt[n] - ONE;
                if (bus.snap)
                    shadow[n] <= cnt[n];
            end
        end
    end

    // Out-of-range channel or byte selects simply match nothing and read as zero.
    always_comb begin
        rd_byte = 8'h00;
        for (int n = 0; n < CHANNELS; n++) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (bus.sel == 3'(n) && bus.byte_sel == 2'(b))
                    rd_byte = shadow[n][8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            dout_r <= 8'h00;
        else
            dout_r <= rd_byte;
    end

    assign dout = bus.oe ? dout_r : 8'bz;

`ifdef COUNTER_BANK_ERR_EN
    logic [CHANNELS-1:0] err_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_r <= '0;
        else
            err_r <= illegal | (err_r & ~{CHANNELS{bus.clr_err}});
    end

    assign bus.err = err_r;
`else
    logic [CHANNELS:0] unused_err;

    assign unused_err = {bus.clr_err, illegal};
    assign bus.err    = '0;
`endif
endmodule

// File: doc/quad_counter_bank.md
# quad_counter_bank

Multi-channel incremental-encoder counter: synchronises and debounces up to 8 quadrature inputs, decodes each in a per-channel runtime-selectable mode (full x4 or div4), and accumulates into SIZE-bit wrap-around counters. A single snapshot strobe copies all counters coherently into shadow registers, which the host then reads one byte at a time over the shared 8-bit tristate bus. It is the parametrised successor of the fixed 4-channel, 8-bit counter top of the asserv programmable-logic design.

## Interface

- CHANNELS, 4: number of encoder channels, 1..8.
- SIZE, 16: counter width in bits; multiple of 8, 8..32.
- FILTER_LEN, 3: debounce length in cycles, 1..15.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- q  in  2*CHANNELS  raw encoder inputs; channel n is q[2n+1:2n] = {A,B}.
- mode  in  CHANNELS  per-channel decode mode: 1 = full x4, 0 = div4.
- snap  in  1  snapshot strobe, one-cycle pulse.
- sel  in  3  channel select for read.
- byte  in  2  byte select for read; 0 = LSB.
- oe  in  1  output enable: 1 drives dout, 0 leaves it high-Z.
- dout  out  8  read data.
- err  out  CHANNELS  sticky illegal-transition flags.
- clr_err  in  1  clears all err flags.

## Operation

- **Reset values:** all counters, shadows and the dout register are 0; err is 0; synchroniser, filter state and the previous-state register (prev) are 00; filter counters are 0.
- **Synchroniser:** 2 flip-flops per input bit.
- **Filter:** one per bit. The filtered value takes the synchronised value on the edge where the two have differed for FILTER_LEN consecutive cycles. Any cycle where they agree resets the filter counter to 0.
- **Decoder:**
  - Registers prev = filtered {A,B} every cycle.
  - Forward sequence is 00→01→11→10→00.
  - Full mode: +1 for each forward step, −1 for each reverse step.
  - Div4 mode: +1 only on 10→00, −1 only on 00→10; all other legal steps count 0.
  - No change: count 0.
  - Both bits changing: illegal, counts 0.
- **Counter:** modulo 2^SIZE; 0 − 1 = all ones, all ones + 1 = 0.
- **Mode switch:** mode is sampled every cycle. A change applies to the next transition; the counter is not adjusted.
- **Snapshot:** when snap = 1 at a clock edge, every shadow[n] takes counter[n]'s pre-edge value in that same edge. Counting is never stalled. Back-to-back snaps are legal.
- **Read:** each edge, the dout register takes shadow[sel][8*byte+7 : 8*byte]. It takes 0 if sel ≥ CHANNELS or byte ≥ SIZE/8. dout = oe ? register : 8'bz.
- **Error (only when COUNTER_BANK_ERR_EN is defined):**
  - An illegal transition sets err[n].
  - clr_err clears all flags.
  - A set and a clear in the same cycle: set wins.

## Timing

- **Input to counter latency:** q changes before edge 1; synchronised value visible after edge 2; filtered value after edge 2+FILTER_LEN; counter updated after edge 3+FILTER_LEN. With the default FILTER_LEN = 3, that is edge 6.
- **Minimum pulse width:** input pulses shorter than FILTER_LEN cycles, measured post-sync, are rejected.
- **Read latency:** sel/byte/snap stable before edge k gives dout valid after edge k.
  - A snap at edge k is readable after edge k+1.
  - oe→dout is combinational.
- **Reset mid-operation:** rst asserted takes all state immediately to reset values; dout becomes high-Z or 0 per oe. The first count after release follows the full latency above.

## Configuration

- **COUNTER_BANK_ERR_EN defined:** illegal-transition detection is present; err and clr_err behave as described in Operation.
- **COUNTER_BANK_ERR_EN undefined:** no err flops are built; err is tied to 0 and clr_err is ignored. Illegal transitions still count 0 and still update prev.

## Test plan

- **Reset:** hold rst = 0 with q toggling, oe = 1, sel = 0, byte = 0 → dout = 0x00 and err = 0; with oe = 0 → dout = z.
- **Full mode up and down:** SIZE = 16, mode[0] = 1. Apply 5 forward steps on ch0, each held 8 cycles, then snap and read bytes 0 and 1 → 0x05, 0x00. Then apply 6 reverse steps, snap and read → 0xFF, 0xFF (wrap).
- **Div4:** mode[1] = 0. Apply 8 forward steps on ch1 → count 2. Then alternate 00↔10 three times, ending at 00 → count unchanged at 2.
- **Debounce:** FILTER_LEN = 3. A 2-cycle glitch 00→01→00 on ch2 → count 0. A 3-cycle hold at 01 → count 1, appearing exactly 6 edges after the input change.
- **Coherent snapshot:** ch0 and ch3 both counting. Snap, then continue stepping for 20 cycles → reads return the values at the snap edge. sel = 5 with CHANNELS = 4 → 0x00.
- **Error (COUNTER_BANK_ERR_EN):** a 00→11 step on ch1 → err = 4'b0010 and count unchanged. Pulse clr_err in the same cycle as a new illegal step → err stays set; pulse clr_err alone → err = 0.
